// File: rtl/parity_frame_if.sv
// Handshake bundle for the parity frame controller: frame input channel and result output channel.
// The controller takes the slave side; the frame source/result consumer takes the master side.
interface parity_frame_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_par;
   logic             out_valid;
   logic             out_ready;
   logic             out_err;
   logic             out_par;

   modport master (
      output in_valid, in_data, in_par, out_ready,
      input  in_ready, out_valid, out_err, out_par
   );

   modport slave (
      input  in_valid, in_data, in_par, out_ready,
      output in_ready, out_valid, out_err, out_par
   );
endinterface

// File: rtl/parity_frame_controller.sv
// Serialises each accepted frame LSB first through a running-parity register and reports
// pass/fail against the transmitted parity bit, with a saturating error counter.
module parity_frame_controller #(
   parameter int WIDTH      = 8,
   parameter bit ODD_PARITY = 1'b0,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   parity_frame_if.slave    bus,
   output logic             busy,
   output logic [CNT_W-1:0] err_count,
   input  logic             clr_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int             CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    bit_cnt;
   logic             parity;
   logic             held_par;
   logic             last_bit;
   logic             err_nxt;

   assign last_bit = (bit_cnt == LAST);
   // Error as it will stand once the final bit has been folded in on this edge
   assign err_nxt  = parity ^ sreg[0] ^ held_par ^ ODD_PARITY;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid) state_nxt = SHIFT;
         SHIFT:   if (last_bit)     state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sreg     <= '0;
         bit_cnt  <= '0;
         parity   <= 1'b0;
         held_par <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  sreg     <= bus.in_data;
                  held_par <= bus.in_par;
                  parity   <= 1'b0;
                  bit_cnt  <= '0;
               end
            end
            SHIFT: begin
               parity  <= parity ^ sreg[0];
               sreg    <= sreg >> 1;
               bit_cnt <= bit_cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   // Clear beats a same-edge increment; the count sticks at all-ones
   always_ff @(posedge clk) begin
      if (rst)
         err_count <= '0;
      else if (clr_count)
         err_count <= '0;
      else if (state == SHIFT && last_bit && err_nxt && err_count != CNT_MAX)
         err_count <= err_count + CNT_W'(1);
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.out_par   = (state == DONE) & parity;
   assign bus.out_err   = (state == DONE) & (parity ^ held_par ^ ODD_PARITY);
   assign busy          = (state != IDLE);

endmodule

// File: tb/tb_parity_frame_controller.sv
// Bench for parity_frame_controller: two instances (default, and odd parity with 2-bit counter)
// checked every cycle against a frame-age reference model, plus directed literal expectations.
module tb_parity_frame_controller;
   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic busy0, busy1;
   logic [7:0] cnt0;
   logic [1:0] cnt1;

   logic         dv   [2];
   logic         dp   [2];
   logic         dr   [2];
   logic         dclr [2];
   logic [W-1:0] dd   [2];

   parity_frame_if #(.WIDTH(W)) bus0 ();
   parity_frame_if #(.WIDTH(W)) bus1 ();

   assign bus0.in_valid  = dv[0];
   assign bus0.in_data   = dd[0];
   assign bus0.in_par    = dp[0];
   assign bus0.out_ready = dr[0];
   assign bus1.in_valid  = dv[1];
   assign bus1.in_data   = dd[1];
   assign bus1.in_par    = dp[1];
   assign bus1.out_ready = dr[1];

   parity_frame_controller #(.WIDTH(W), .ODD_PARITY(1'b0), .CNT_W(8)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0.slave), .busy(busy0), .err_count(cnt0), .clr_count(dclr[0])
   );
   parity_frame_controller #(.WIDTH(W), .ODD_PARITY(1'b1), .CNT_W(2)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1.slave), .busy(busy1), .err_count(cnt1), .clr_count(dclr[1])
   );

   int errors = 0;
   int checks = 0;
   bit en = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int g_rdy(input int i);  return (i == 0) ? int'(bus0.in_ready)  : int'(bus1.in_ready);  endfunction
   function automatic int g_vld(input int i);  return (i == 0) ? int'(bus0.out_valid) : int'(bus1.out_valid); endfunction
   function automatic int g_err(input int i);  return (i == 0) ? int'(bus0.out_err)   : int'(bus1.out_err);   endfunction
   function automatic int g_par(input int i);  return (i == 0) ? int'(bus0.out_par)   : int'(bus1.out_par);   endfunction
   function automatic int g_busy(input int i); return (i == 0) ? int'(busy0) : int'(busy1); endfunction
   function automatic int g_cnt(input int i);  return (i == 0) ? int'(cnt0)  : int'(cnt1);  endfunction

   // Reference model: a frame is "in flight" from acceptance until consumed; its result is
   // visible once W edges have elapsed since acceptance.
   bit           m_busy [2];
   int           m_age  [2];
   logic [W-1:0] m_data [2];
   bit           m_par  [2];
   int           m_cnt  [2];

   function automatic int m_odd(input int i);  return (i == 0) ? 0 : 1;   endfunction
   function automatic int m_cmax(input int i); return (i == 0) ? 255 : 3; endfunction
   function automatic int m_fail(input int i);
      return int'((^m_data[i]) ^ m_par[i]) ^ m_odd(i);
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_busy[i] = 1'b0;
            m_age[i]  = 0;
            m_cnt[i]  = 0;
         end else begin
            if (!m_busy[i]) begin
               if (dv[i]) begin
                  m_busy[i] = 1'b1;
                  m_age[i]  = 0;
                  m_data[i] = dd[i];
                  m_par[i]  = dp[i];
               end
            end else if (m_age[i] < W) begin
               m_age[i]++;
               if (m_age[i] == W && m_fail(i) == 1 && m_cnt[i] < m_cmax(i)) m_cnt[i]++;
            end else if (dr[i]) begin
               m_busy[i] = 1'b0;
            end
            if (dclr[i]) m_cnt[i] = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (en) begin
         for (int i = 0; i < 2; i++) begin
            int ev;
            ev = (m_busy[i] && m_age[i] == W) ? 1 : 0;
            chk($sformatf("model_in_ready%0d", i),  g_rdy(i),  m_busy[i] ? 0 : 1);
            chk($sformatf("model_out_valid%0d", i), g_vld(i),  ev);
            chk($sformatf("model_out_err%0d", i),   g_err(i),  ev ? m_fail(i) : 0);
            chk($sformatf("model_out_par%0d", i),   g_par(i),  ev ? int'(^m_data[i]) : 0);
            chk($sformatf("model_busy%0d", i),      g_busy(i), int'(m_busy[i]));
            chk($sformatf("model_err_count%0d", i), g_cnt(i),  m_cnt[i]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Runs one frame on instance i from an idle controller; returns the result seen in DONE.
   task automatic frame(input int i, input logic [W-1:0] d, input logic p, input int hold,
                        input bit clr_done, output int o_err, output int o_par, output int o_cnt);
      chk("frame_start_ready", g_rdy(i), 1);
      dv[i] = 1'b1; dd[i] = d; dp[i] = p; dr[i] = 1'b0;
      step();
      dv[i] = 1'b0; dd[i] = W'($urandom); dp[i] = 1'($urandom);
      for (int k = 1; k <= W; k++) begin
         if (k == W && clr_done) dclr[i] = 1'b1;
         dd[i] = W'($urandom); dp[i] = 1'($urandom);
         step();
         dclr[i] = 1'b0;
         if (k == W - 1) chk("valid_not_early", g_vld(i), 0);
      end
      chk("valid_at_width", g_vld(i), 1);
      o_err = g_err(i);
      o_par = g_par(i);
      o_cnt = g_cnt(i);
      for (int h = 0; h < hold; h++) begin
         step();
         chk("hold_valid", g_vld(i), 1);
         chk("hold_in_ready", g_rdy(i), 0);
         chk("hold_err", g_err(i), o_err);
      end
      dr[i] = 1'b1;
      step();
      dr[i] = 1'b0;
      chk("idle_after_consume_valid", g_vld(i), 0);
      chk("idle_after_consume_ready", g_rdy(i), 1);
   endtask

   int e, p, c;
   int exp_cnt5 [5] = '{1, 2, 3, 3, 3};

   initial begin
      for (int i = 0; i < 2; i++) begin
         dv[i] = 1'b0; dp[i] = 1'b0; dr[i] = 1'b0; dclr[i] = 1'b0; dd[i] = '0;
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      en = 1'b1;
      step();
      rst = 1'b0;
      chk("reset_in_ready", g_rdy(0), 1);
      chk("reset_out_valid", g_vld(0), 0);
      chk("reset_busy", g_busy(0), 0);
      chk("reset_err_count", g_cnt(0), 0);

      frame(0, 8'hA5, 1'b0, 0, 1'b0, e, p, c);
      chk("a5_err", e, 0); chk("a5_par", p, 0); chk("a5_cnt", c, 0);

      frame(0, 8'h07, 1'b0, 0, 1'b0, e, p, c);
      chk("07p0_err", e, 1); chk("07p0_par", p, 1); chk("07p0_cnt", c, 1);
      frame(0, 8'h07, 1'b1, 0, 1'b0, e, p, c);
      chk("07p1_err", e, 0); chk("07p1_cnt", c, 1);

      frame(0, 8'h81, 1'b1, 5, 1'b0, e, p, c);
      chk("hold_err_lit", e, 1); chk("hold_par_lit", p, 0); chk("hold_cnt_lit", c, 2);

      frame(1, 8'h00, 1'b1, 0, 1'b0, e, p, c);
      chk("odd_00p1_err", e, 0);
      frame(1, 8'h00, 1'b0, 0, 1'b0, e, p, c);
      chk("odd_00p0_err", e, 1); chk("odd_00p0_cnt", c, 1);

      dclr[1] = 1'b1;
      step();
      dclr[1] = 1'b0;
      chk("clr_idle", g_cnt(1), 0);
      for (int n = 0; n < 5; n++) begin
         frame(1, 8'h00, 1'b0, 0, 1'b0, e, p, c);
         chk($sformatf("sat_cnt_%0d", n), c, exp_cnt5[n]);
      end
      frame(1, 8'h00, 1'b0, 0, 1'b1, e, p, c);
      chk("clr_beats_inc", c, 0);

      dv[0] = 1'b1; dd[0] = 8'hFF; dp[0] = 1'b1;
      step();
      dv[0] = 1'b0;
      for (int k = 1; k <= 3; k++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_in_ready", g_rdy(0), 1);
      chk("abort_out_valid", g_vld(0), 0);
      chk("abort_err_count", g_cnt(0), 0);
      for (int k = 0; k < W + 2; k++) begin
         step();
         chk("abort_no_result", g_vld(0), 0);
      end
      frame(0, 8'hFF, 1'b1, 0, 1'b0, e, p, c);
      chk("post_abort_err", e, 1); chk("post_abort_par", p, 0); chk("post_abort_cnt", c, 1);

      for (int t = 0; t < 4000; t++) begin
         for (int i = 0; i < 2; i++) begin
            dv[i]   = 1'($urandom);
            dd[i]   = W'($urandom);
            dp[i]   = 1'($urandom);
            dr[i]   = ($urandom_range(0, 3) != 0);
            dclr[i] = ($urandom_range(0, 63) == 0);
         end
         rst = ($urandom_range(0, 499) == 0);
         step();
      end
      rst = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
